keypad_scanner: RTL

- Input-side counterpart to the display path. The 7-segment decoder turns a 4-bit digit into segments; this block turns a physical 4x4 hex keypad into a 4-bit digit.
- Drives keypad columns one at a time, samples the rows, debounces, and encodes the pressed key to a hex code with a one-cycle valid strobe.
- Sits between the board pins and the ALU operand/display logic in top.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_tick_gen.sv | 35 +++
 rtl/keypad_scanner.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 hex keypad scanner.
// Auto-repeat constants exist only when KEYPAD_REPEAT_EN is defined.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Result of looking for exactly one active-low row
    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_hit_t;

    // Key code per {row, col}, row-major
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REPEAT_DELAY_TICKS  = 500;
    localparam int unsigned REPEAT_PERIOD_TICKS = 100;
`endif

    // Flags whether exactly one row is low and reports which one
    function automatic row_hit_t find_single_low(input logic [3:0] rows);
        row_hit_t    hit;
        int unsigned lows;
        hit  = '0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                lows    = lows + 1;
                hit.idx = 2'(i);
            end
        end
        hit.single = (lows == 1);
        return hit;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick: one-cycle pulse every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 27000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned    CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Counter wraps at SCAN_DIV-1; tick is registered so it is high while count sits at LAST
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, row sync, debounce, hex encode.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 27000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int unsigned      REP_W     = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY_TICKS);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD_TICKS);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic             rep_armed_q, rep_armed_d;
`endif

    logic [3:0]       row_meta_q, row_s_q;
    logic             tick;
    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d, col_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    row_hit_t         hit;
    logic             same_row;
    logic             cand_high;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchroniser for the asynchronous row pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_s_q    <= '0;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
        end
    end

    assign hit       = find_single_low(row_s_q);
    assign same_row  = hit.single && (hit.idx == cand_row_q);
    assign cand_high = row_s_q[cand_row_q];
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign col_next  = col_q + 2'd1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: all decisions are taken on scan ticks only
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit.single) state_d = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!same_row)               state_d = SCAN;
                    else if (cnt_inc == DB_LAST) state_d = HELD;
                end
                HELD: begin
                    if (cand_high) state_d = (DEBOUNCE_TICKS == 1) ? SCAN : RELEASE;
                end
                RELEASE: begin
                    if (!cand_high)              state_d = HELD;
                    else if (cnt_inc == DB_LAST) state_d = SCAN;
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // FSM outputs and datapath next values
    always_comb begin
        col_d       = col_q;
        cnt_d       = cnt_q;
        cand_row_d  = cand_row_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_inc     = rep_cnt_q + REP_W'(1);
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit.single) begin
                        cand_row_d = hit.idx;
                        cnt_d      = '0;
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (same_row) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_LAST) begin
                            key_code_d  = KEY_MAP[{cand_row_q, col_q}];
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b0;
`endif
                        end
                    end else begin
                        col_d = col_next;
                        cnt_d = '0;
                    end
                end
                HELD: begin
                    if (cand_high) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            key_held_d = 1'b0;
                            col_d      = col_next;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else begin
                        // First repeat after the delay, then one per period
                        if (rep_inc == (rep_armed_q ? REP_PERIOD : REP_DELAY)) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
                    end
`endif
                end
                RELEASE: begin
                    if (cand_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_LAST) begin
                            key_held_d = 1'b0;
                            col_d      = col_next;
                            cnt_d      = '0;
                        end
                    end else begin
                        cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
        col_out_d = ~(4'b0001 << col_d);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            cnt_q       <= '0;
            cand_row_q  <= '0;
            col_out_q   <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            cand_row_q  <= cand_row_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
